sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command/burst port between two requesters: the video framebuffer fetcher (port V, read-only) and the CPU cache line fill/writeback engine (port C, read/write).
- Sits between those requesters and the SDRAM controller, in the sdrclk domain.
- Sequences one burst at a time. It issues the rd/wr pulse, counts the controller's get/put word strobes to detect the end of the burst, and returns a done pulse to the owner.
- Video has priority. A streak limit bounds how long the cache can be starved.

Parameters:
- ADDR_W, 12: burst (line) address width on the controller port.
- DATA_W, 16: controller word width.
- BURST_LEN, 8: get/put strobes per burst. Must be at least 2.
- MAX_STREAK, 4: maximum consecutive video grants while the cache is waiting. Must be at least 1.

Ports:
- clk  in  1  sdrclk domain clock.
- rst  in  1  reset. Asynchronous, active-high.
- v_req  in  1  video burst-read request, level.
- v_addr  in  ADDR_W  video burst address. Stable while v_req=1.
- v_gnt  out  1  video owns the controller.
- v_get  out  1  read-word strobe forwarded to video.
- v_done  out  1  one-cycle end-of-burst pulse to video.
- c_req  in  1  cache burst request, level.
- c_we  in  1  1 = writeback, 0 = fill. Stable while c_req=1.
- c_addr  in  ADDR_W  cache burst address.
- c_wdata  in  DATA_W  writeback word. Must be valid whenever c_put is sampled.
- c_gnt  out  1  cache owns the controller.
- c_get  out  1  read-word strobe forwarded to cache.
- c_put  out  1  write-word strobe forwarded to cache.
- c_done  out  1  one-cycle end-of-burst pulse to cache.
- m_addr  out  ADDR_W  controller burst address.
- m_rd  out  1  controller read command pulse.
- m_wr  out  1  controller write command pulse.
- m_din  out  DATA_W  write data to controller.
- m_get  in  1  controller read-word strobe.
- m_put  in  1  controller write-word strobe.
- m_dout  is not routed through this block. Read data goes directly to both requesters, qualified by v_get/c_get.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, owner=none, beat counter=0, streak=0. All outputs 0; m_addr=0.
- Reset asserted mid-burst aborts the burst. No done pulse is issued. The controller is reset by the same system reset.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE, arbitration:
  - Video is chosen if v_req=1 and not (c_req=1 and streak==MAX_STREAK).
  - Otherwise the cache is chosen if c_req=1.
  - Otherwise stay in IDLE.
  - On a choice: register owner, address and direction (video is always read), then go to ISSUE.
  - With both requests continuously high the grant pattern is V×MAX_STREAK, C, repeating.
- Streak counter:
  - +1 on each video grant made while c_req=1, saturating at MAX_STREAK.
  - Cleared on a cache grant.
  - Cleared on a video grant made while c_req=0.
- ISSUE: exactly one cycle.
  - m_rd=1 for a read, or m_wr=1 for a write.
  - m_addr holds the latched address from ISSUE through DONE.
  - Next state is XFER.
- XFER:
  - m_get/m_put are combinationally forwarded only to the owner, as v_get or c_get/c_put.
  - m_din = c_wdata combinationally.
  - The beat counter increments on the direction-relevant strobe.
  - The strobe that brings the count to BURST_LEN moves to DONE and clears the counter.
  - A strobe of the wrong direction is ignored and not forwarded.
- DONE: exactly one cycle.
  - Owner's done=1, then go to IDLE.
  - The requester must drop req in the DONE cycle unless it wants another burst. req is re-sampled in IDLE.
  - Minimum gap is therefore one IDLE cycle between bursts.
- Grants: the owner's gnt is 1 from ISSUE through DONE inclusive. v_gnt and c_gnt are never high together.
- Strobes arriving in IDLE, ISSUE or DONE are ignored and never forwarded.
- A requester dropping req mid-burst has no effect; the burst completes.
- All outputs except the forwarded strobes and m_din are registered or decoded directly from state. There is no combinational path from *_req to m_*.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - the state enum (IDLE/ISSUE/XFER/DONE);
  - the owner encoding (OWN_NONE/OWN_V/OWN_C);
  - default BURST_LEN.
- The priority/streak logic is a natural sub-module, arb_prio_streak: inputs v_req, c_req, grant_evt; outputs pick_v, pick_c.
- Everything else stays in the top module.

Test Plan:
- Reset released, only v_req=1, v_addr=12'h123 → v_gnt rises in the ISSUE cycle with m_rd=1 and m_addr=12'h123. 8 m_get pulses are each forwarded to v_get. v_done=1 one cycle after the 8th. No c_get pulses.
- Only c_req=1, c_we=1, c_addr=12'h0A5 → m_wr pulse. 8 m_put pulses are forwarded to c_put, with m_din tracking c_wdata (0x1111..0x8888). c_done follows, and m_rd stays 0.
- v_req and c_req held high for 10 bursts, MAX_STREAK=4 → grant order V,V,V,V,C,V,V,V,V,C. v_gnt and c_gnt are never high together.
- Spurious m_get in IDLE, and m_put during a video read → no forwarded strobe, beat count unaffected, burst still ends after 8 m_get.
- rst asserted after 3 beats of a cache fill → all outputs 0 asynchronously and no c_done. After release with c_req still 1, a fresh ISSUE occurs and the full 8 beats complete.
- c_req raised in the DONE cycle of a video burst → cache granted from the following IDLE: ISSUE appears exactly 2 cycles after v_done.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg: shared state/owner encodings and defaults for the SDRAM port arbiter.
package sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_V, OWN_C} owner_t;
    localparam int DEF_BURST_LEN = 8;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester-side and controller-side signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              v_req;
    logic [ADDR_W-1:0] v_addr;
    logic              v_gnt;
    logic              v_get;
    logic              v_done;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_get;
    logic              c_put;
    logic              c_done;
    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_din;
    logic              m_get;
    logic              m_put;
    modport slave (
        input  v_req, v_addr, c_req, c_we, c_addr, c_wdata, m_get, m_put,
        output v_gnt, v_get, v_done, c_gnt, c_get, c_put, c_done, m_addr, m_rd, m_wr, m_din
    );
    modport master (
        output v_req, v_addr, c_req, c_we, c_addr, c_wdata, m_get, m_put,
        input  v_gnt, v_get, v_done, c_gnt, c_get, c_put, c_done, m_addr, m_rd, m_wr, m_din
    );
endinterface

// File: rtl/sdram_port_arbiter_prio_streak.sv
// arb_prio_streak: video-first priority with a streak limit that bounds cache starvation.
module arb_prio_streak #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic v_req,
    input  logic c_req,
    input  logic grant_evt,
    output logic pick_v,
    output logic pick_c
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    logic [SW-1:0] streak_q, streak_d;
    assign pick_v = v_req && !(c_req && streak_q == SW'(MAX_STREAK));
    assign pick_c = c_req && !pick_v;
    // A video grant with the cache waiting implies streak < MAX_STREAK, so +1 saturates naturally
    always_comb begin
        streak_d = !grant_evt ? streak_q : (pick_v && c_req) ? streak_q + SW'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) streak_q <= '0;
        else     streak_q <= streak_d;
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller burst port between video (read-only) and cache.
// One burst at a time: issue rd/wr, count direction-matched word strobes, pulse done to the owner.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int MAX_STREAK = 4
) (
    input logic                 clk,
    input logic                 rst,
    sdram_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              pick_v, pick_c, grant_evt, xfer, strobe, last, wr_xfer;

    arb_prio_streak #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .v_req     (bus.v_req),
        .c_req     (bus.c_req),
        .grant_evt (grant_evt),
        .pick_v    (pick_v),
        .pick_c    (pick_c)
    );

    assign grant_evt = state_q == IDLE && (pick_v || pick_c);
    assign xfer      = state_q == XFER;
    assign strobe    = xfer && (we_q ? bus.m_put : bus.m_get);
    assign last      = beat_q == BW'(BURST_LEN - 1);
    assign wr_xfer   = xfer && owner_q == OWN_C && we_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (grant_evt) begin
                state_d = ISSUE;
                owner_d = pick_v ? OWN_V : OWN_C;
                addr_d  = pick_v ? bus.v_addr : bus.c_addr;
                we_d    = pick_c && bus.c_we;
            end
            ISSUE: state_d = XFER;
            XFER: if (strobe) begin
                state_d = last ? DONE : XFER;
                beat_d  = last ? '0 : beat_q + BW'(1);
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
        end
    end

    // Owner is cleared on leaving DONE, so grants follow owner alone
    assign bus.v_gnt  = owner_q == OWN_V;
    assign bus.c_gnt  = owner_q == OWN_C;
    assign bus.v_get  = xfer && owner_q == OWN_V && bus.m_get;
    assign bus.c_get  = xfer && owner_q == OWN_C && !we_q && bus.m_get;
    assign bus.c_put  = wr_xfer && bus.m_put;
    assign bus.v_done = state_q == DONE && owner_q == OWN_V;
    assign bus.c_done = state_q == DONE && owner_q == OWN_C;
    assign bus.m_addr = addr_q;
    assign bus.m_rd   = state_q == ISSUE && !we_q;
    assign bus.m_wr   = state_q == ISSUE && we_q;
    assign bus.m_din  = bus.c_wdata & {DATA_W{wr_xfer}};
endmodule
